// File: rtl/adder_test_pkg.sv
// Shared types and constants for the full-adder self-test controller.
package adder_test_pkg;

   localparam int unsigned NUM_VECTORS = 8;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned ERR_W       = 4;
   localparam int unsigned SETTLE_W    = 4;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

endpackage

// File: rtl/golden_full_adder.sv
// Reference full adder producing the expected response for the vector under test.
module golden_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic exp_sum,
   output logic exp_cout
);

   always_comb begin
      exp_sum  = a ^ b ^ cin;
      exp_cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/adder_self_test.sv
// Exhaustive 8-vector self-test of an external 1-bit full adder, with a check that the
// spare sum_2 output stays quiet (a nonzero value flags a possible trojan).
module adder_self_test
   import adder_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   tv_a,
   output logic                   tv_b,
   output logic                   tv_cin,
   input  logic                   dut_sum,
   input  logic                   dut_cout,
   input  logic                   dut_sum_2,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [ERR_W-1:0]       err_count,
   output logic [NUM_VECTORS-1:0] fail_vec,
   output logic                   trojan_flag
);

   localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [IDX_W-1:0]    LastIdx    = IDX_W'(NUM_VECTORS - 1);

   state_e                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic [SETTLE_W-1:0]      settle_q;
   logic [IDX_W-1:0]         tv_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     pass_q;
   logic [ERR_W-1:0]         err_q;
   logic [NUM_VECTORS-1:0]   fail_q;
   logic                     trojan_q;

   logic                     exp_sum;
   logic                     exp_cout;
   logic                     sum_bad;
   logic                     cout_bad;
   logic                     sum2_bad;
   logic                     vec_bad;
   logic [ERR_W-1:0]         err_next;

   golden_full_adder u_golden (
      .a        (tv_q[2]),
      .b        (tv_q[1]),
      .cin      (tv_q[0]),
      .exp_sum  (exp_sum),
      .exp_cout (exp_cout)
   );

   always_comb begin
      sum_bad  = dut_sum != exp_sum;
      cout_bad = dut_cout != exp_cout;
      sum2_bad = dut_sum_2 != 1'b0;
      vec_bad  = sum_bad | cout_bad | sum2_bad;
      // One increment per vector regardless of how many outputs disagree.
      err_next = err_q + ERR_W'(vec_bad);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         settle_q <= '0;
         tv_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fail_q   <= '0;
         trojan_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StDrive;
                  idx_q    <= '0;
                  tv_q     <= '0;
                  settle_q <= SettleLoad;
                  busy_q   <= 1'b1;
                  pass_q   <= 1'b0;
                  err_q    <= '0;
                  fail_q   <= '0;
                  trojan_q <= 1'b0;
               end
            end
            StDrive: begin
               state_q <= StSettle;
            end
            StSettle: begin
               settle_q <= settle_q - 1'b1;
               // Guard against <= 1 so an out-of-range load still terminates.
               if (settle_q <= SETTLE_W'(1)) begin
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               if (vec_bad) begin
                  fail_q[idx_q] <= 1'b1;
                  err_q         <= err_next;
               end
               if (sum2_bad) begin
                  trojan_q <= 1'b1;
               end
               if (idx_q == LastIdx) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  pass_q  <= (err_next == '0);
               end else begin
                  state_q  <= StDrive;
                  idx_q    <= idx_q + 1'b1;
                  tv_q     <= idx_q + 1'b1;
                  settle_q <= SettleLoad;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tv_a        = tv_q[2];
   assign tv_b        = tv_q[1];
   assign tv_cin      = tv_q[0];
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_count   = err_q;
   assign fail_vec    = fail_q;
   assign trojan_flag = trojan_q;

endmodule

// File: doc/adder_self_test.md
ADDER_SELF_TEST -- requirements
Module: adder_self_test

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the DUT settle cycles per vector (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, level-sampled request to run one test pass.
REQ-005 The block SHALL have ports tv_a, tv_b, tv_cin, output, 1 each, registered test vector driven to the DUT a, b, cin inputs.
REQ-006 The block SHALL have ports dut_sum, dut_cout, dut_sum_2, input, 1 each, DUT responses.
REQ-007 The block SHALL have port busy, output, 1, high from the first DRIVE cycle until DONE exits.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse at end of pass.
REQ-009 The block SHALL have port pass, output, 1, high when the last completed pass had zero failures.
REQ-010 The block SHALL have port err_count, output, 4, number of failing vectors in the last pass (0..8).
REQ-011 The block SHALL have port fail_vec, output, 8, bit i set when vector i failed.
REQ-012 The block SHALL have port trojan_flag, output, 1, set when dut_sum_2 was nonzero on any checked vector.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the FSM SHALL move to DRIVE with vector index idx=0 and clear err_count, fail_vec, trojan_flag, pass.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 Vector idx (3-bit) SHALL map {tv_a,tv_b,tv_cin} = idx; tv outputs update in DRIVE and hold through SETTLE and CHECK.
REQ-017 DRIVE SHALL last 1 cycle, SETTLE exactly SETTLE_CYCLES cycles (settle counter reloads on DRIVE entry), CHECK 1 cycle.
REQ-018 In CHECK the block SHALL compare dut_sum to a^b^cin, dut_cout to majority(a,b,cin), dut_sum_2 to 0.
REQ-019 Any mismatch in CHECK SHALL set fail_vec[idx], increment err_count by 1 (at most once per vector), and a dut_sum_2 mismatch SHALL additionally set trojan_flag.
REQ-020 From CHECK, idx<7 SHALL go to DRIVE with idx+1; idx=7 SHALL go to DONE (no wrap to vector 0 within a pass).
REQ-021 DONE SHALL last 1 cycle with done=1, pass=(err_count==0) taking effect the same edge, then return to IDLE.
REQ-022 Done SHALL assert 8*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start.
REQ-023 Results (pass, err_count, fail_vec, trojan_flag) SHALL hold until the next accepted start or reset.
REQ-024 start=1 in the DONE cycle SHALL be ignored; start=1 on the first IDLE cycle after DONE SHALL begin a new pass.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, idx=0, settle counter 0, tv_a=tv_b=tv_cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, trojan_flag=0.
REQ-026 Reset mid-pass SHALL abort the pass with no done pulse; first pass after deassertion requires a new start.

Structure
REQ-027 Package adder_test_pkg SHALL hold the state enum typedef, NUM_VECTORS=8, and constant widths of idx and err_count.
REQ-028 Expected-value generation SHALL live in one combinational sub-module golden_full_adder (inputs a,b,cin; outputs exp_sum, exp_cout).

Verification
REQ-029 Correct DUT model, SETTLE_CYCLES=2, start pulse -> done at cycle 33, pass=1, err_count=0, fail_vec=8'h00, trojan_flag=0.
REQ-030 DUT with sum stuck-0 -> fail_vec=8'b1001_0110, err_count=4, pass=0, trojan_flag=0.
REQ-031 DUT with cout stuck-1 -> fail_vec=8'b0001_0111, err_count=4, pass=0.
REQ-032 DUT with sum_2 tied 1, sum/cout correct -> fail_vec=8'hFF, err_count=8, trojan_flag=1, pass=0.
REQ-033 start held high for 100 cycles -> exactly two passes, done pulses at cycles 33 and 67; no restart mid-pass.
REQ-034 rst_n low during CHECK of idx=3 -> all outputs at reset values asynchronously, no done; later start gives full clean pass.
